seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, clock cycles each digit is driven (>=2).
REQ-003 SHALL have parameter GAP, default 2, dead-time clock cycles before each digit (>=1).
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  input  1  request to accept data_in.
REQ-007 SHALL have port ready  output  1  shadow buffer empty; load accepted when load&ready.
REQ-008 SHALL have port data_in  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (digit 0 = bits 3:0).
REQ-009 SHALL have port blank_mask  input  NUM_DIGITS  bit k=1 blanks digit k.
REQ-010 SHALL have port seg  output  7  segments, active-high, seg[6]=a .. seg[0]=g.
REQ-011 SHALL have port an  output  NUM_DIGITS  digit select, active-high, at most one bit set.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at frame boundary.

Function
REQ-013 SHALL scan digits 0,1,..,NUM_DIGITS-1, wrapping to 0; each digit slot is GAP cycles then DIV cycles.
REQ-014 SHALL use two states: GAP_S (an=0, seg=0, GAP cycles) and DRIVE_S (DIV cycles); GAP_S->DRIVE_S after GAP cycles; DRIVE_S->GAP_S of next digit after DIV cycles.
REQ-015 In DRIVE_S for unblanked digit k, an SHALL be one-hot bit k and seg the hex 0-F decode of active nibble k.
REQ-016 Hex decode SHALL be standard: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-017 In DRIVE_S for blanked digit k (blank_mask[k]=1), an and seg SHALL be 0; blank_mask is sampled every cycle.
REQ-018 seg and an SHALL be registered; they change on the clock edge entering each state.
REQ-019 Frame boundary SHALL be the last DRIVE_S cycle of digit NUM_DIGITS-1; frame_done SHALL be 1 on exactly that cycle; period NUM_DIGITS*(GAP+DIV).
REQ-020 On load&ready, data_in SHALL be captured into a shadow register and ready SHALL be 0 from the next cycle.
REQ-021 Shadow SHALL transfer to the active register at the frame boundary; ready SHALL return to 1 the following cycle; new values first appear at digit 0 of the next frame (no tearing).
REQ-022 load while ready=0 SHALL be ignored; shadow unchanged.
REQ-023 load&ready on a frame-boundary cycle SHALL capture into shadow; transfer occurs at the following boundary.
REQ-024 Internal prescaler SHALL count 0..DIV-1 (or 0..GAP-1 in GAP_S) and wrap with no overflow.

Reset
REQ-025 On rst=0, immediately and asynchronously: seg=0, an=0, frame_done=0, ready=1, state=GAP_S, digit index=0, counter=0, active and shadow registers=0.
REQ-026 Reset asserted mid-operation SHALL discard any pending shadow data; after release, scanning restarts at GAP_S of digit 0.

Structure
REQ-027 A shared package SHALL hold the state encoding (GAP_S, DRIVE_S) and the 16-entry hex segment constant table.
REQ-028 Hex decoding SHALL be one combinational sub-module, seg_hex_decode (4-bit in, 7-bit out), instantiated once and shared across digits via the digit-index mux.

Verification (NUM_DIGITS=4, DIV=4, GAP=1)
REQ-029 Release reset, no load -> an=0000 one cycle, then an=0001, seg=1111110 for 4 cycles, then gap, then an=0010.
REQ-030 load=1, data_in=16'h1234 mid-frame -> ready=0 next cycle; next frame digit0 seg=0110011, digit1 1111001, digit2 1101101, digit3 0110000; ready=1 the cycle after the boundary.
REQ-031 data_in=16'hFFFF with load while ready=0 -> ignored; displayed digits remain 4,3,2,1.
REQ-032 blank_mask=4'b0010 -> during digit 1 slot an=0000, seg=0000000 for all 5 cycles; other digits unaffected.
REQ-033 Free run -> frame_done pulses exactly every 20 cycles, one cycle wide.
REQ-034 rst=0 during DRIVE_S of digit 2 with shadow full -> seg=0, an=0, ready=1 without clock edge; after release display shows 0 on digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
// Holds the two-state scan encoding and the hex-to-segment lookup table
// (segments active-high, bit 6 = a ... bit 0 = g).
package seg_scan_ctrl_pkg;

  // GAP_S: dead time with all digits and segments off.
  // DRIVE_S: one digit is actively driven.
  typedef enum logic {
    GAP_S   = 1'b0,
    DRIVE_S = 1'b1
  } scan_state_e;

  localparam int SEG_W = 7;

  // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0.
  localparam logic [SEG_W-1:0] HEX_SEG_TBL [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment decoder (active-high segments).
// Ports: nib_i  - 4-bit hex value
//        seg_o  - 7-bit segment pattern, seg_o[6]=a .. seg_o[0]=g
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = HEX_SEG_TBL[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment display scanner with a double-buffered
// data register. Each digit slot is GAP dead cycles then DIV drive cycles.
// Ports: clk, rst (async active-low), load/ready (shadow buffer handshake),
//        data_in (nibble k -> digit k), blank_mask (bit k blanks digit k),
//        seg/an (registered segment and digit-select outputs),
//        frame_done (pulse on the last drive cycle of the last digit).
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int GAP        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  output logic                    ready,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  // The prescaler is shared by both states, so it is sized for the longer one.
  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIG_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  scan_state_e               state_q, state_d;
  logic [DIG_W-1:0]          digit_q, digit_d;
  logic [CNT_W-1:0]          cnt_q,   cnt_d;
  logic [SEG_W-1:0]          seg_q,   seg_d;
  logic [NUM_DIGITS-1:0]     an_q,    an_d;

  logic [4*NUM_DIGITS-1:0]   active_q;
  logic [4*NUM_DIGITS-1:0]   shadow_q;
  logic                      full_q;

  logic [3:0]                cur_nib;
  logic [SEG_W-1:0]          cur_seg;
  logic                      boundary;
  logic                      load_acc;

  // ---------------------------------------------------------------------
  // Shared decoder: only the digit currently being scanned is decoded.
  // digit_q is the right select for the next DRIVE_S cycle, because DRIVE_S
  // is only ever entered from GAP_S of the same digit or continued within it.
  // ---------------------------------------------------------------------
  assign cur_nib = active_q[{digit_q, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  // ---------------------------------------------------------------------
  // Scan FSM: next state and next registered outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q + CNT_W'(1);
    seg_d   = '0;
    an_d    = '0;

    unique case (state_q)
      GAP_S: begin
        if (cnt_q == GAP_LAST) begin
          state_d = DRIVE_S;
          cnt_d   = '0;
        end
      end
      DRIVE_S: begin
        if (cnt_q == DIV_LAST) begin
          state_d = GAP_S;
          cnt_d   = '0;
          digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DIG_W'(1);
        end
      end
      default: begin
        state_d = GAP_S;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed from the state being entered so that seg/an
    // change on the same edge as the state register.
    if ((state_d == DRIVE_S) && !blank_mask[digit_q]) begin
      an_d  = NUM_DIGITS'(1) << digit_q;
      seg_d = cur_seg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GAP_S;
      digit_q <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      an_q    <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // ---------------------------------------------------------------------
  // Double buffer. The active register only changes on the frame boundary,
  // so a frame never shows a mix of old and new digits.
  // ---------------------------------------------------------------------
  assign boundary = (state_q == DRIVE_S) && (digit_q == DIGIT_LAST) &&
                    (cnt_q == DIV_LAST);
  assign load_acc = load && !full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
    end else if (boundary && full_q) begin
      active_q <= shadow_q;
      full_q   <= 1'b0;
    end else if (load_acc) begin
      // A load on a boundary with an empty shadow lands here and waits
      // for the following boundary.
      shadow_q <= data_in;
      full_q   <= 1'b1;
    end
  end

  assign ready      = !full_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = boundary;

endmodule
